mem_wb_stage: RTL

MEM/WB pipeline register with integrated writeback data selection for the 5-stage MIPS pipeline. Sits directly downstream of the EXE/MEM holder and data memory: captures the writeback control signals, ALU result and memory read word at the end of MEM, and presents a single resolved register-file write (enable, address, data) in WB. It also supports stall/flush and keeps a retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: resolves writeback data, qualifies the RF write, counts retirements.
// Optional macro MEM_WB_SIGN_EXT_EN: byte loads sign-extend (lb) instead of zero-extend (lbu).
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_MEM_valid,
  input  logic              in_MEM_Reg_Write_ctrl,
  input  logic              in_MEM_Mem_Or_Reg,
  input  logic              in_MEM_Byte_word,
  input  logic [DATA_W-1:0] in_MEM_ALU_Result,
  input  logic [DATA_W-1:0] in_MEM_Read_Data,
  input  logic [ADDR_W-1:0] in_MEM_Reg_Write_Address,
  input  logic              stall,
  input  logic              flush,
  output logic              out_MEM_WB_valid,
  output logic              out_MEM_WB_Reg_Write_ctrl,
  output logic [ADDR_W-1:0] out_MEM_WB_Reg_Write_Address,
  output logic [DATA_W-1:0] out_MEM_WB_Write_Data,
  output logic [31:0]       out_MEM_WB_Retire_Count
);

  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [31:0]       retire_cnt_q, retire_cnt_d;
  logic [DATA_W-1:0] wb_data_s;
  logic              we_qual_s;

  // Little-endian byte lane pick from a 32-bit word.
  function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] extend_byte(input logic [7:0] b);
`ifdef MEM_WB_SIGN_EXT_EN
    return {{24{b[7]}}, b};
`else
    return {24'h00_0000, b};
`endif
  endfunction

  // Writeback data mux and write-enable qualification on MEM-side inputs.
  always_comb begin
    wb_data_s = in_MEM_ALU_Result;
    if (in_MEM_Mem_Or_Reg == 1'b0) begin
      wb_data_s = in_MEM_ALU_Result;
    end else if (in_MEM_Byte_word == 1'b0) begin
      wb_data_s = in_MEM_Read_Data;
    end else begin
      wb_data_s = extend_byte(pick_byte(in_MEM_Read_Data, in_MEM_ALU_Result[1:0]));
    end
    // $0 is hardwired zero: the write is dropped but the instruction still retires.
    we_qual_s = in_MEM_Reg_Write_ctrl & in_MEM_valid &
                (in_MEM_Reg_Write_Address != {ADDR_W{1'b0}});
  end

  // Next-state selection: flush > stall > load (reset is handled in the register block).
  always_comb begin
    valid_d      = valid_q;
    we_d         = we_q;
    addr_d       = addr_q;
    data_d       = data_q;
    retire_cnt_d = retire_cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
      addr_d  = {ADDR_W{1'b0}};
      data_d  = {DATA_W{1'b0}};
    end else if (stall) begin
      valid_d      = valid_q;
      we_d         = we_q;
      addr_d       = addr_q;
      data_d       = data_q;
      retire_cnt_d = retire_cnt_q;
    end else begin
      valid_d = in_MEM_valid;
      we_d    = we_qual_s;
      addr_d  = in_MEM_Reg_Write_Address;
      data_d  = wb_data_s;
      if (in_MEM_valid) begin
        retire_cnt_d = retire_cnt_q + 32'd1;
      end else begin
        retire_cnt_d = retire_cnt_q;
      end
    end
  end

  // WB state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      data_q       <= {DATA_W{1'b0}};
      retire_cnt_q <= 32'h0000_0000;
    end else begin
      valid_q      <= valid_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign out_MEM_WB_valid             = valid_q;
  assign out_MEM_WB_Reg_Write_ctrl    = we_q;
  assign out_MEM_WB_Reg_Write_Address = addr_q;
  assign out_MEM_WB_Write_Data         = data_q;
  assign out_MEM_WB_Retire_Count      = retire_cnt_q;

endmodule
